// File: rtl/dmem_lane_ctrl_if.sv
// Handshake and lane-RAM bus for the data-memory load/store front end.
// slave = controller side, master = pipeline/memory side.
interface dmem_lane_ctrl_if #(parameter int ADDR_W = 16);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [1:0]        req_size_i;
    logic              req_unsigned_i;
    logic [31:0]       req_wdata_i;
    logic              rsp_valid_o;
    logic [31:0]       rsp_rdata_o;
    logic [ADDR_W-3:0] mem_addr_o;
    logic [3:0]        mem_wren_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i,
               req_wdata_i, mem_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, mem_addr_o, mem_wren_o,
               mem_wdata_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i,
               req_wdata_i, mem_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, mem_addr_o, mem_wren_o,
               mem_wdata_o
    );
endinterface

// File: rtl/dmem_lane_ctrl.sv
// Byte/half/word load-store front end over four 8-bit lane RAMs; accesses
// crossing a word boundary take a second (SPLIT) cycle on the next word.
module dmem_lane_ctrl #(
    parameter int ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    dmem_lane_ctrl_if.slave   bus
);
    localparam int WA_W = ADDR_W - 2;

    typedef enum logic {S_IDLE = 1'b0, S_SPLIT = 1'b1} state_t;

    state_t          r_state;
    logic [1:0]      r_size;
    logic [1:0]      r_off;
    logic            r_uns;
    logic            r_we;
    logic [31:0]     r_wdata;
    logic [WA_W-1:0] r_wa_nxt;
    logic [31:0]     r_asm;
    logic            r_rsp_valid;
    logic [31:0]     r_rdata;

    logic [1:0]      w_off;
    logic [1:0]      w_size;
    logic            w_uns;
    logic            w_we;
    logic [31:0]     w_wdata;
    logic [2:0]      w_nb;
    logic [2:0]      w_end;
    logic            w_cross;
    logic [3:0]      w_mask;
    logic [31:0]     w_wrot;
    logic [31:0]     w_lanes;
    logic [31:0]     w_ord;
    logic [31:0]     w_res;
    logic            w_idle;

    assign w_idle = (r_state == S_IDLE);

    // In SPLIT every attribute comes from the registered request, since the
    // pipeline may already present the next one on the bus.
    always_comb begin
        w_off   = w_idle ? bus.req_addr_i[1:0]  : r_off;
        w_size  = w_idle ? bus.req_size_i       : r_size;
        w_uns   = w_idle ? bus.req_unsigned_i   : r_uns;
        w_we    = w_idle ? bus.req_we_i         : r_we;
        w_wdata = w_idle ? bus.req_wdata_i      : r_wdata;

        case (w_size)
            2'b00:   w_nb = 3'd1;
            2'b01:   w_nb = 3'd2;
            default: w_nb = 3'd4;
        endcase
        w_end   = {1'b0, w_off} + w_nb;
        w_cross = (w_end > 3'd4);

        w_mask = '0;
        for (int k = 0; k < 4; k++) begin
            if (w_idle)
                w_mask[k] = (3'(k) >= {1'b0, w_off}) && (3'(k) < w_end);
            else
                w_mask[k] = (3'(k) + 3'd4) < w_end;
        end

        // Store byte j lands on lane (off+j) mod 4.
        case (w_off)
            2'd0:    w_wrot = w_wdata;
            2'd1:    w_wrot = {w_wdata[23:0], w_wdata[31:24]};
            2'd2:    w_wrot = {w_wdata[15:0], w_wdata[31:16]};
            default: w_wrot = {w_wdata[7:0],  w_wdata[31:8]};
        endcase

        // Second half: lanes read this cycle merge with the first-half capture.
        w_lanes = bus.mem_rdata_i;
        for (int k = 0; k < 4; k++) begin
            if (!w_idle && !w_mask[k])
                w_lanes[8*k +: 8] = r_asm[8*k +: 8];
        end

        case (w_off)
            2'd0:    w_ord = w_lanes;
            2'd1:    w_ord = {w_lanes[7:0],  w_lanes[31:8]};
            2'd2:    w_ord = {w_lanes[15:0], w_lanes[31:16]};
            default: w_ord = {w_lanes[23:0], w_lanes[31:24]};
        endcase

        case (w_size)
            2'b00:   w_res = {{24{~w_uns & w_ord[7]}},  w_ord[7:0]};
            2'b01:   w_res = {{16{~w_uns & w_ord[15]}}, w_ord[15:0]};
            default: w_res = w_ord;
        endcase
    end

    assign bus.req_ready_o = w_idle;
    assign bus.mem_addr_o  = w_idle ? bus.req_addr_i[ADDR_W-1:2] : r_wa_nxt;
    assign bus.mem_wren_o  = (w_we && (!w_idle || bus.req_valid_i)) ? w_mask : 4'b0000;
    assign bus.mem_wdata_o = w_wrot;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_rdata_o = r_rdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_size      <= '0;
            r_off       <= '0;
            r_uns       <= 1'b0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_wa_nxt    <= '0;
            r_asm       <= '0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (r_state == S_IDLE) begin
                if (bus.req_valid_i) begin
                    r_size   <= bus.req_size_i;
                    r_off    <= bus.req_addr_i[1:0];
                    r_uns    <= bus.req_unsigned_i;
                    r_we     <= bus.req_we_i;
                    r_wdata  <= bus.req_wdata_i;
                    r_wa_nxt <= bus.req_addr_i[ADDR_W-1:2] + {{(WA_W-1){1'b0}}, 1'b1};
                    if (!bus.req_we_i)
                        r_asm <= bus.mem_rdata_i;
                    if (w_cross) begin
                        r_state <= S_SPLIT;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_rdata     <= bus.req_we_i ? 32'h0 : w_res;
                    end
                end
            end else begin
                if (!r_we)
                    r_asm <= w_lanes;
                r_rsp_valid <= 1'b1;
                r_rdata     <= r_we ? 32'h0 : w_res;
                r_state     <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_dmem_lane_ctrl.sv
// Directed bench for dmem_lane_ctrl: lane RAM model, expected responses queued
// at acceptance and checked by an independent monitor.
module tb_dmem_lane_ctrl;
    logic clk;
    logic rst_n;
    int   cyc;
    int   n_pass;
    int   n_total;
    int   w;
    logic [31:0] last_rd;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t q[$];

    logic [7:0] ram [4][16384];

    dmem_lane_ctrl_if #(.ADDR_W(16)) bus ();

    dmem_lane_ctrl #(.ADDR_W(16)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int k = 0; k < 4; k++)
            for (int a = 0; a < 16384; a++)
                ram[k][a] = 8'h00;
    end

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (bus.mem_wren_o[k])
                ram[k][bus.mem_addr_o] <= bus.mem_wdata_o[8*k +: 8];
    end

    always_comb begin
        bus.mem_rdata_i = '0;
        for (int k = 0; k < 4; k++)
            bus.mem_rdata_i[8*k +: 8] = ram[k][bus.mem_addr_o];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // Monitor: every response pops the scoreboard; between responses the
    // registered read data must hold.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_rd = 32'h0;
        end else if (bus.rsp_valid_o) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_rsp: got rdata %h with no pending request", bus.rsp_rdata_o);
            end else begin
                e = q.pop_front();
                chk("rsp_rdata", bus.rsp_rdata_o, e.data);
                chk("rsp_latency_cycle", 32'(cyc), 32'(e.due));
            end
            last_rd = bus.rsp_rdata_o;
        end else begin
            chk("rdata_hold", bus.rsp_rdata_o, last_rd);
        end
    end

    task automatic setreq(input logic we, input logic [15:0] a, input logic [1:0] sz,
                          input logic u, input logic [31:0] wd);
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = we;
        bus.req_addr_i     = a;
        bus.req_size_i     = sz;
        bus.req_unsigned_i = u;
        bus.req_wdata_i    = wd;
    endtask

    // Wait for acceptance (bounded), queue the expected response, return just
    // after the accepting edge.
    task automatic accept(input logic [31:0] exp, input int lat, input bit push, output int waits);
        waits = 0;
        @(negedge clk);
        while (!bus.req_ready_o && waits < 8) begin
            waits++;
            @(negedge clk);
        end
        if (!bus.req_ready_o) begin
            n_total++;
            $display("FAIL accept_timeout: ready stayed %b, expected 1", bus.req_ready_o);
        end else if (push) begin
            q.push_back('{exp, cyc + lat});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid_i = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        setreq(1'b0, 16'h0, 2'b00, 1'b0, 32'h0);
        idle();
        #3;
        chk("rst_ready", 32'(bus.req_ready_o), 32'h1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
        chk("rst_rdata", bus.rsp_rdata_o, 32'h0);
        chk("rst_wren", 32'(bus.mem_wren_o), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // aligned word store / load
        setreq(1'b1, 16'h0010, 2'b10, 1'b0, 32'h12345678); #1;
        chk("st_w_addr", 32'(bus.mem_addr_o), 32'h0004);
        chk("st_w_wren", 32'(bus.mem_wren_o), 32'hF);
        chk("st_w_wdata", bus.mem_wdata_o, 32'h12345678);
        accept(32'h0, 1, 1'b1, w);
        setreq(1'b0, 16'h0010, 2'b10, 1'b0, 32'h0);
        accept(32'h12345678, 1, 1'b1, w);

        // byte / half with extension
        setreq(1'b1, 16'h0021, 2'b00, 1'b0, 32'h00000080); #1;
        chk("st_b_wren", 32'(bus.mem_wren_o), 32'h2);
        chk("st_b_lane1", 32'(bus.mem_wdata_o[15:8]), 32'h80);
        accept(32'h0, 1, 1'b1, w);
        setreq(1'b0, 16'h0021, 2'b00, 1'b0, 32'h0);
        accept(32'hFFFFFF80, 1, 1'b1, w);
        setreq(1'b0, 16'h0021, 2'b00, 1'b1, 32'h0);
        accept(32'h00000080, 1, 1'b1, w);
        setreq(1'b1, 16'h0022, 2'b01, 1'b0, 32'h00008001); #1;
        chk("st_h_wren", 32'(bus.mem_wren_o), 32'hC);
        chk("st_h_lanes23", 32'(bus.mem_wdata_o[31:16]), 32'h8001);
        accept(32'h0, 1, 1'b1, w);
        setreq(1'b0, 16'h0022, 2'b01, 1'b0, 32'h0);
        accept(32'hFFFF8001, 1, 1'b1, w);

        // crossing word store at 0x0003
        setreq(1'b1, 16'h0003, 2'b10, 1'b0, 32'hAABBCCDD); #1;
        chk("x_c1_addr", 32'(bus.mem_addr_o), 32'h0);
        chk("x_c1_wren", 32'(bus.mem_wren_o), 32'h8);
        chk("x_c1_lane3", 32'(bus.mem_wdata_o[31:24]), 32'hDD);
        accept(32'h0, 2, 1'b1, w);
        idle(); #1;
        chk("x_c2_ready", 32'(bus.req_ready_o), 32'h0);
        chk("x_c2_addr", 32'(bus.mem_addr_o), 32'h1);
        chk("x_c2_wren", 32'(bus.mem_wren_o), 32'h7);
        chk("x_c2_lanes012", 32'(bus.mem_wdata_o[23:0]), 32'hAABBCC);
        setreq(1'b0, 16'h0003, 2'b10, 1'b0, 32'h0);
        accept(32'hAABBCCDD, 2, 1'b1, w);
        chk("x_ld_wait", 32'(w), 32'h1);
        idle();

        // wrap-around store at 0xFFFE
        setreq(1'b1, 16'hFFFE, 2'b10, 1'b0, 32'h01020304);
        accept(32'h0, 2, 1'b1, w);
        chk("wrap_c1_wait", 32'(w), 32'h1);
        idle(); #1;
        chk("wrap_c2_addr", 32'(bus.mem_addr_o), 32'h0000);
        chk("wrap_c2_wren", 32'(bus.mem_wren_o), 32'h3);
        chk("wrap_c2_lanes01", 32'(bus.mem_wdata_o[15:0]), 32'h0102);
        chk("wrap_ram_3fff", {ram[3][16383], ram[2][16383], 16'h0}, 32'h03040000);
        setreq(1'b0, 16'hFFFE, 2'b10, 1'b0, 32'h0);
        accept(32'h01020304, 2, 1'b1, w);
        idle();
        @(posedge clk); #1;

        // back-to-back loads, then a crossing load inserting one bubble
        setreq(1'b0, 16'h0010, 2'b10, 1'b0, 32'h0);
        accept(32'h12345678, 1, 1'b1, w);
        chk("b2b_wait0", 32'(w), 32'h0);
        setreq(1'b0, 16'h0020, 2'b10, 1'b0, 32'h0);
        accept(32'h80018000, 1, 1'b1, w);
        chk("b2b_wait1", 32'(w), 32'h0);
        setreq(1'b0, 16'h0004, 2'b10, 1'b0, 32'h0);
        accept(32'h00AABBCC, 1, 1'b1, w);
        chk("b2b_wait2", 32'(w), 32'h0);
        setreq(1'b0, 16'h0023, 2'b01, 1'b0, 32'h0);
        accept(32'h00000080, 2, 1'b1, w);
        setreq(1'b0, 16'h0005, 2'b00, 1'b1, 32'h0);
        accept(32'h000000BB, 1, 1'b1, w);
        chk("bubble_wait", 32'(w), 32'h1);
        setreq(1'b0, 16'h0006, 2'b00, 1'b0, 32'h0);
        accept(32'hFFFFFFAA, 1, 1'b1, w);
        chk("after_bubble_wait", 32'(w), 32'h0);
        idle();
        repeat (3) @(posedge clk);
        #1;

        // reset during SPLIT of a crossing store
        setreq(1'b1, 16'h0102, 2'b10, 1'b0, 32'h11223344); #1;
        chk("rs_c1_wren", 32'(bus.mem_wren_o), 32'hC);
        accept(32'h0, 2, 1'b0, w);
        idle(); #1;
        chk("rs_in_split", 32'(bus.req_ready_o), 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rs_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
        chk("rs_wren_off", 32'(bus.mem_wren_o), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rs_ready_after", 32'(bus.req_ready_o), 32'h1);
        chk("rs_no_rsp", 32'(bus.rsp_valid_o), 32'h0);
        @(posedge clk); #1;
        setreq(1'b0, 16'h0100, 2'b10, 1'b0, 32'h0);
        accept(32'h33440000, 1, 1'b1, w);
        setreq(1'b0, 16'h0104, 2'b10, 1'b0, 32'h0);
        accept(32'h00000000, 1, 1'b1, w);
        idle();

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/dmem_lane_ctrl.md
# dmem_lane_ctrl

Load/store front end for the data memory built from four 8-bit byte-lane RAMs (8x16k each, asynchronous read, synchronous write). It accepts byte/half/word requests from the pipeline's memory stage over a valid/ready handshake and drives the shared word address, per-lane write enables and lane data. It reassembles and sign-extends load data and returns a registered response. Accesses that cross a 32-bit word boundary are split into two memory cycles.

## Interface
- ADDR_W, 16, byte-address width; word address to the lanes is ADDR_W-2 = 14 bits
- clk_i  in  1  clock; all state updates on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  request can be accepted; transfer occurs when valid & ready
- req_we_i  in  1  1 = store, 0 = load
- req_addr_i  in  16  byte address
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
- req_unsigned_i  in  1  1 = zero-extend load, 0 = sign-extend
- req_wdata_i  in  32  store data; byte j goes to address A+j
- rsp_valid_o  out  1  one-cycle pulse per completed request, loads and stores
- rsp_rdata_o  out  32  load result; 0 for stores
- mem_addr_o  out  14  word address shared by all four lanes
- mem_wren_o  out  4  per-lane write enable; lane k holds bytes with addr[1:0]==k
- mem_wdata_o  out  32  lane k data on bits [8k+7:8k]
- mem_rdata_i  in  32  lane k asynchronous read data on bits [8k+7:8k]

## Operation
- Definitions: A = req_addr_i; off = A[1:0]; W = A[15:2]; n = 1, 2 or 4 bytes from size. Byte j (0..n-1) lives in lane (off+j) mod 4. It is in word W if off+j<4, else in word W+1.
- W+1 wraps modulo 2^14: 0x3FFF+1 = 0x0000.
- The request crosses a word boundary when off+n > 4.
- State IDLE:
  - req_ready_o = 1; mem_addr_o = W.
  - mem_wren_o[k] = valid & we & (lane k holds a byte of the request in word W).
  - On acceptance, register size, unsigned, we, wdata, off and W+1.
  - For loads, capture the word-W bytes from mem_rdata_i into the assembly register.
  - Crossing request: go to SPLIT. Otherwise pulse rsp_valid_o the next cycle and stay in IDLE.
- State SPLIT:
  - req_ready_o = 0; mem_addr_o = registered W+1.
  - mem_wren_o is set for lanes 0..(off+n-5) if the request is a store.
  - For loads, capture those lanes into the assembly register.
  - Return to IDLE; pulse rsp_valid_o the next cycle.
- Result: assembled bytes 0..n-1 form the low n bytes of rsp_rdata_o.
  - Upper bytes are the sign of bit 8n-1 when req_unsigned_i = 0, else 0.
  - Word size ignores the unsigned flag.
- Stores: rsp_rdata_o = 0. Lanes without a write enable hold their memory contents.
- mem_wdata_o lane k always carries the store byte destined for that lane; its value is don't-care when the lane's enable is 0.
- No enable is asserted without an accepted request (IDLE) or an active SPLIT.

## Timing
- Reset values:
  - state IDLE.
  - req_ready_o = 1, rsp_valid_o = 0, rsp_rdata_o = 0, mem_wren_o = 0 while req_valid_i = 0, assembly register = 0.
- Latency, non-crossing: response 1 cycle after acceptance. Throughput is 1 request per cycle; the response of request i coincides with acceptance of request i+1.
- Latency, crossing: response 2 cycles after acceptance; req_ready_o is low for exactly 1 cycle.
- rsp_rdata_o is registered and stable while rsp_valid_o = 1. It holds its value until the next response.
- Writes commit on the rising edge ending the cycle in which the enable is asserted.
- Load of a location stored in the previous cycle returns the new data, because memory reads are asynchronous.
- Reset asserted during SPLIT:
  - The second-half write is suppressed and no response is issued.
  - The first-half write has already committed; this is accepted behaviour.

## Test plan
- Aligned store then load: word 0x12345678 to 0x0010 gives mem_addr 0x0004, wren 4'b1111 in 1 cycle. Loading 0x0010 gives rsp_valid 1 cycle later with rdata 0x12345678.
- Byte extension: store byte 0x80 to 0x0021 gives wren 4'b0010. Signed load byte returns 0xFFFFFF80; unsigned returns 0x00000080. Half 0x8001 at 0x0022, signed, returns 0xFFFF8001.
- Crossing word store: 0xAABBCCDD to 0x0003.
  - Cycle 1: addr 0, wren 4'b1000, lane 3 = 0xDD.
  - Cycle 2: ready 0, addr 1, wren 4'b0111, lanes 0-2 = CC/BB/AA.
  - Loading it back returns 0xAABBCCDD with 2-cycle latency.
- Wrap-around: word store 0x01020304 to 0xFFFE writes word 0x3FFF lanes 2-3 (04, 03), then word 0x0000 lanes 0-1 (02, 01). Load back matches.
- Back-to-back: valid held for 3 accepted aligned loads on consecutive cycles gives 3 consecutive rsp_valid pulses with correct data. A crossing load inserts exactly one ready = 0 bubble.
- Reset during SPLIT of a crossing store: only the first-half lanes change. rsp_valid stays 0, and ready = 1 after release.
